// File: rtl/fir_seq_pkg.sv
// fir_seq shared types and helpers.
// Also reused by the RNS filter variant.
package fir_seq_pkg;

  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    DONE
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Modular multiply-accumulate for the FIR core.
// acc shows the running sum including the current product.
module fir_mac_unit
  import fir_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              clear,
  input  logic              en,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] prod;

  assign prod = a * b;
  assign acc  = acc_q + prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/fir_seq_top.sv
// FIR sequencer: load coefficients and samples,
// run a time-multiplexed MAC, buffer results.
module fir_seq_top
  import fir_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TAPS    = 10,
  parameter int SAMPLES = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [cnt_w(TAPS)-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [31:0]              rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int AW = cnt_w(TAPS);
  localparam int NW = cnt_w(SAMPLES);

  state_t            state;
  logic [NW-1:0]     cnt;
  logic [NW-1:0]     n;
  logic [AW-1:0]     k;
  logic [DATA_W-1:0] coef [TAPS];
  logic [DATA_W-1:0] samp [SAMPLES];
  logic [DATA_W-1:0] res  [SAMPLES];
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [DATA_W-1:0] acc;
  logic              take;
  logic              last_tap;
  logic              last_n;
  logic              cfg_ok;

  assign busy    = (state == LOAD) || (state == MAC);
  assign done    = (state == DONE);
  assign s_ready = (state == LOAD);
  assign take    = s_valid && s_ready;

  assign last_tap = (k == AW'(TAPS - 1));
  assign last_n   = (n == NW'(SAMPLES - 1));

  assign cfg_ok = cfg_we
               && ((state == IDLE) || (state == DONE))
               && (32'(cfg_addr) < 32'(TAPS));

  // Taps reaching before x[0] contribute zero.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    if (32'(k) <= 32'(n)) begin
      mac_a = coef[k];
      mac_b = samp[NW'(32'(n) - 32'(k))];
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .a     (mac_a),
    .b     (mac_b),
    .clear ((state != MAC) || last_tap),
    .en    (state == MAC),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      n       <= '0;
      k       <= '0;
      rd_data <= '0;
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
      for (int i = 0; i < SAMPLES; i++) begin
        samp[i] <= '0;
        res[i]  <= '0;
      end
    end else begin
      if (cfg_ok) coef[cfg_addr] <= cfg_data;
      rd_data <= (rd_addr < 32'(SAMPLES))
               ? res[rd_addr[NW-1:0]] : '0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            cnt   <= '0;
            n     <= '0;
            k     <= '0;
          end
        end
        LOAD: begin
          if (take) begin
            samp[cnt] <= s_data;
            if (cnt == NW'(SAMPLES - 1)) begin
              state <= MAC;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        MAC: begin
          if (last_tap) begin
            res[n] <= acc;
            k      <= '0;
            if (last_n) state <= DONE;
            else n <= n + 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_top.sv
// Self-checking bench for fir_seq_top: table vectors,
// corner sequences and random runs against a convolution model.
module tb_fir_seq_top;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 64-bit, 3-tap, 4-sample instance
  logic        cfg_we = 0;
  logic [1:0]  cfg_addr = 0;
  logic [63:0] cfg_data = 0;
  logic        start = 0;
  logic        busy, done, s_ready;
  logic        s_valid = 0;
  logic [63:0] s_data = 0;
  logic [31:0] rd_addr = 0;
  logic [63:0] rd_data;

  fir_seq_top #(.DATA_W(64), .TAPS(3), .SAMPLES(4)) u_a (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // 8-bit, 1-tap, 2-sample instance for wrap-around
  logic        b_cfg_we = 0;
  logic [0:0]  b_cfg_addr = 0;
  logic [7:0]  b_cfg_data = 0;
  logic        b_start = 0;
  logic        b_busy, b_done, b_s_ready;
  logic        b_s_valid = 0;
  logic [7:0]  b_s_data = 0;
  logic [31:0] b_rd_addr = 0;
  logic [7:0]  b_rd_data;

  fir_seq_top #(.DATA_W(8), .TAPS(1), .SAMPLES(2)) u_b (
    .clk(clk), .reset(reset),
    .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
    .start(b_start), .busy(b_busy), .done(b_done),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // y[n] = sum_k h[k]*x[n-k] mod 2^64, x[j<0] = 0
  function automatic logic [3:0][63:0] model(input logic [2:0][63:0] h,
                                             input logic [3:0][63:0] x);
    logic [3:0][63:0] y;
    logic [63:0] acc, p;
    for (int nn = 0; nn < 4; nn++) begin
      acc = 0;
      for (int kk = 0; kk < 3; kk++) begin
        if (kk <= nn) begin
          p = h[kk] * x[nn-kk];
          acc = acc + p;
        end
      end
      y[nn] = acc;
    end
    return y;
  endfunction

  task automatic write_h(input logic [2:0][63:0] h);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      cfg_we = 1; cfg_addr = 2'(j); cfg_data = h[j];
    end
    @(negedge clk);
    cfg_we = 0;
  endtask

  // cyc counts rising edges from the start edge until done is seen.
  task automatic run(input logic [3:0][63:0] x, input bit gaps,
                     input bit poke, output int cyc, output int rdy_bad);
    int i, t;
    i = 0; t = 0; rdy_bad = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 200) begin
      start = poke && (t == 1);
      cfg_we = poke && (t == 8);
      cfg_addr = 0; cfg_data = 64'd99;
      if (s_ready !== (i < 4)) rdy_bad++;
      if (s_ready && i < 4 && (!gaps || t % 2 == 0)) begin
        s_valid = 1; s_data = x[i]; i++;
      end else begin
        s_valid = 0;
      end
      t++;
      @(negedge clk);
      cyc++;
    end
    start = 0; cfg_we = 0; s_valid = 0;
  endtask

  task automatic read_chk(input string name, input logic [3:0][63:0] exp);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      rd_addr = j;
      @(negedge clk);
      chk($sformatf("%s[%0d]", name, j), rd_data, exp[j]);
    end
  endtask

  typedef struct packed {
    logic [2:0][63:0] h;
    logic [3:0][63:0] x;
    logic [3:0][63:0] y;
  } vec_t;

  vec_t tbl [3];
  logic [2:0][63:0] h_step, h_r;
  logic [3:0][63:0] x_step, x_r, zero4;
  int cyc, bad, wc;
  bit g;

  initial begin
    // packed concatenations list the highest index first
    tbl[0].h = {64'd3, 64'd2, 64'd1};
    tbl[0].x = {64'd0, 64'd0, 64'd0, 64'd1};
    tbl[0].y = {64'd0, 64'd3, 64'd2, 64'd1};
    tbl[1].h = {64'd3, 64'd2, 64'd1};
    tbl[1].x = {64'd1, 64'd1, 64'd1, 64'd1};
    tbl[1].y = {64'd6, 64'd6, 64'd3, 64'd1};
    tbl[2].h = {64'd3, 64'd2, 64'd1};
    tbl[2].x = {64'd0, 64'd0, 64'd0, 64'd2};
    tbl[2].y = {64'd0, 64'd6, 64'd4, 64'd2};
    h_step = tbl[1].h;
    x_step = tbl[1].x;
    zero4 = '0;

    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_b_rd_data", 64'(b_rd_data), 0);
    @(negedge clk);
    reset = 0;

    for (int v = 0; v < 3; v++) begin
      write_h(tbl[v].h);
      run(tbl[v].x, 0, 0, cyc, bad);
      chk($sformatf("tbl%0d_latency", v), 64'(cyc), 17);
      chk($sformatf("tbl%0d_s_ready", v), 64'(bad), 0);
      read_chk($sformatf("tbl%0d_y", v), tbl[v].y);
    end

    @(negedge clk);
    rd_addr = 7;
    @(negedge clk);
    chk("rd_out_of_range", rd_data, 0);

    run(x_step, 1, 0, cyc, bad);
    chk("gap_latency", 64'(cyc), 20);
    chk("gap_s_ready", 64'(bad), 0);
    read_chk("gap_y", tbl[1].y);

    run(x_step, 0, 1, cyc, bad);
    chk("poke_latency", 64'(cyc), 17);
    read_chk("poke_y", tbl[1].y);

    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 3; j++) h_r[j] = {$urandom, $urandom};
      for (int j = 0; j < 4; j++) x_r[j] = {$urandom, $urandom};
      g = 1'($urandom_range(0, 1));
      write_h(h_r);
      run(x_r, g, 0, cyc, bad);
      chk($sformatf("rnd%0d_latency", r), 64'(cyc), g ? 20 : 17);
      read_chk($sformatf("rnd%0d_y", r), model(h_r, x_r));
    end

    // 8-bit wrap; coefficient written in the same cycle as start
    @(negedge clk);
    b_cfg_we = 1; b_cfg_addr = 0; b_cfg_data = 8'd16; b_start = 1;
    @(negedge clk);
    b_cfg_we = 0; b_start = 0; b_s_valid = 1; b_s_data = 8'd16;
    @(negedge clk);
    b_s_data = 8'd17;
    @(negedge clk);
    b_s_valid = 0;
    wc = 3;
    while (!b_done && wc < 50) begin
      @(negedge clk);
      wc++;
    end
    chk("wrap_latency", 64'(wc), 5);
    b_rd_addr = 0;
    @(negedge clk);
    chk("wrap_y0", 64'(b_rd_data), 0);
    b_rd_addr = 1;
    @(negedge clk);
    chk("wrap_y1", 64'(b_rd_data), 16);

    // asynchronous reset in the middle of MAC
    write_h(h_step);
    @(negedge clk);
    rd_addr = 1; start = 1;
    @(negedge clk);
    start = 0; s_valid = 1; s_data = 1;
    repeat (4) @(negedge clk);
    s_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("mac_busy", 64'(busy), 1);
    reset = 1;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_done", 64'(done), 0);
    chk("arst_rd_data", rd_data, 0);
    @(negedge clk);
    reset = 0;
    chk("post_rst_busy", 64'(busy), 0);
    chk("post_rst_s_ready", 64'(s_ready), 0);
    read_chk("post_rst_y", zero4);
    chk("post_rst_idle", 64'({busy, done}), 0);
    // coefficients were cleared, so a fresh run yields zeros
    run(x_step, 0, 0, cyc, bad);
    chk("zero_h_latency", 64'(cyc), 17);
    read_chk("zero_h_y", zero4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
